// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HALT controller.
// Define FETCH_PERF_EN to add the fetch_count / stall_count performance counters.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [31:0] HALT_WORD = 32'hEAFF_FFFF;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pc_out_next, inst_out_next;
  logic        valid_next;
  logic        fetch_load;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4  = pc + 32'd4;
  assign target    = branch_addr & 32'hFFFF_FFFC;
  assign inst_addr = pc;
  assign halted    = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pc        <= 32'd0;
      pc_out    <= 32'd0;
      inst_out  <= 32'd0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      pc_out    <= pc_out_next;
      inst_out  <= inst_out_next;
      valid_out <= valid_next;
    end
  end

  // Priority in both states: branch redirect, then freeze, then normal progress.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    pc_out_next   = pc_out;
    inst_out_next = inst_out;
    valid_next    = valid_out;
    fetch_load    = 1'b0;

    unique case (state)
      RUN: begin
        if (branch_taken) begin
          pc_next       = target;
          pc_out_next   = 32'd0;
          inst_out_next = 32'd0;
          valid_next    = 1'b0;
        end else if (!freeze) begin
          fetch_load    = 1'b1;
          pc_out_next   = pc_plus4;
          inst_out_next = inst_in;
          valid_next    = 1'b1;
          if (inst_in == HALT_WORD) begin
            state_next = HALT;
          end else begin
            pc_next = pc_plus4;
          end
        end
      end
      HALT: begin
        if (branch_taken) begin
          pc_out_next   = 32'd0;
          inst_out_next = 32'd0;
          valid_next    = 1'b0;
          if (target != pc) begin
            pc_next    = target;
            state_next = RUN;
          end
        end else if (!freeze) begin
          pc_out_next   = 32'd0;
          inst_out_next = 32'd0;
          valid_next    = 1'b0;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  // A stall cycle is any freeze that is not overridden by a branch, in either state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (fetch_load) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (freeze && !branch_taken) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`else
  logic unused_fetch_load;
  assign unused_fetch_load = fetch_load;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational instruction memory model.
// Memory words are MOV r0,#(addr[9:2]) unless the halt word is planted at haltAddr.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] inst_addr;
  logic [31:0] inst_in;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic        haltEn;
  logic [31:0] haltAddr;
  int          checks;
  int          errors;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .inst_addr   (inst_addr),
    .inst_in     (inst_in),
    .pc_out      (pc_out),
    .inst_out    (inst_out),
    .valid_out   (valid_out),
    .halted      (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (haltEn && inst_addr == haltAddr) inst_in = 32'hEAFF_FFFF;
    else inst_in = 32'hE3A0_0000 | {24'h0, inst_addr[9:2]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Concatenated view is {inst_addr, pc_out, inst_out, valid_out, halted}.
  task automatic test_reset();
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = 32'd0;
    haltEn = 1'b0;
    haltAddr = 32'd0;
    step();
    step();
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'd0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'd0, 32'd0, 32'd0, 1'b0, 1'b0});
    end
`ifdef FETCH_PERF_EN
    checks++;
    if ({fetch_count, stall_count} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_counters got %h expected %h", {fetch_count, stall_count}, 64'd0);
    end
`endif
    rst = 1'b0;
    #2;
    checks++;
    if (inst_addr !== 32'd0) begin
      errors++;
      $display("[TB] FAIL first_fetch_addr got %h expected %h", inst_addr, 32'd0);
    end
  endtask

  task automatic test_sequential();
    step();
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'd4, 32'd4, 32'hE3A00000, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL seq_fetch0 got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'd4, 32'd4, 32'hE3A00000, 1'b1, 1'b0});
    end
    step();
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'd8, 32'd8, 32'hE3A00001, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL seq_fetch4 got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'd8, 32'd8, 32'hE3A00001, 1'b1, 1'b0});
    end
    step();
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'd12, 32'd12, 32'hE3A00002, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL seq_fetch8 got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'd12, 32'd12, 32'hE3A00002, 1'b1, 1'b0});
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'd12, 32'd12, 32'hE3A00002, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL freeze_hold%0d got %h expected %h", i, {inst_addr, pc_out, inst_out, valid_out, halted}, {32'd12, 32'd12, 32'hE3A00002, 1'b1, 1'b0});
      end
    end
    freeze = 1'b0;
    step();
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'd16, 32'd16, 32'hE3A00003, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL freeze_resume got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'd16, 32'd16, 32'hE3A00003, 1'b1, 1'b0});
    end
  endtask

  task automatic test_branch_over_freeze();
    freeze = 1'b1;
    branch_taken = 1'b1;
    branch_addr = 32'h20;
    step();
    freeze = 1'b0;
    branch_taken = 1'b0;
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'h20, 32'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL branch_freeze got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'h20, 32'd0, 32'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_halt();
    haltEn = 1'b1;
    haltAddr = 32'h20;
    step();
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'h20, 32'h24, 32'hEAFFFFFF, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL halt_latch got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'h20, 32'h24, 32'hEAFFFFFF, 1'b1, 1'b1});
    end
    step();
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'h20, 32'd0, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL halt_bubble got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'h20, 32'd0, 32'd0, 1'b0, 1'b1});
    end
    freeze = 1'b1;
    step();
    freeze = 1'b0;
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'h20, 32'd0, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL halt_freeze got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'h20, 32'd0, 32'd0, 1'b0, 1'b1});
    end
    branch_taken = 1'b1;
    branch_addr = 32'h22;
    step();
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'h20, 32'd0, 32'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL halt_branch_same got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'h20, 32'd0, 32'd0, 1'b0, 1'b1});
    end
    branch_addr = 32'h0;
    step();
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'h0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL halt_branch_exit got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'h0, 32'd0, 32'd0, 1'b0, 1'b0});
    end
    branch_addr = 32'h20;
    step();
    branch_addr = 32'h40;
    step();
    branch_taken = 1'b0;
    haltEn = 1'b0;
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'h40, 32'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL branch_beats_halt got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'h40, 32'd0, 32'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_align_wrap();
    branch_taken = 1'b1;
    branch_addr = 32'h0000_0013;
    step();
    checks++;
    if (inst_addr !== 32'h10) begin
      errors++;
      $display("[TB] FAIL branch_align got %h expected %h", inst_addr, 32'h10);
    end
    branch_addr = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    checks++;
    if (inst_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("[TB] FAIL branch_top got %h expected %h", inst_addr, 32'hFFFF_FFFC);
    end
    step();
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'h0, 32'd0, 32'hE3A000FF, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL pc_wrap got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'h0, 32'd0, 32'hE3A000FF, 1'b1, 1'b0});
    end
`ifdef FETCH_PERF_EN
    checks++;
    if ({fetch_count, stall_count} !== {32'd6, 32'd3}) begin
      errors++;
      $display("[TB] FAIL perf_counts got %h expected %h", {fetch_count, stall_count}, {32'd6, 32'd3});
    end
`endif
  endtask

  task automatic test_reset_mid_halt();
    haltEn = 1'b1;
    haltAddr = 32'h100;
    branch_taken = 1'b1;
    branch_addr = 32'h100;
    step();
    branch_taken = 1'b0;
    step();
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'h100, 32'h104, 32'hEAFFFFFF, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL halt_before_rst got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'h100, 32'h104, 32'hEAFFFFFF, 1'b1, 1'b1});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'd0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_rst got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'd0, 32'd0, 32'd0, 1'b0, 1'b0});
    end
`ifdef FETCH_PERF_EN
    checks++;
    if ({fetch_count, stall_count} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL async_rst_counters got %h expected %h", {fetch_count, stall_count}, 64'd0);
    end
`endif
    haltEn = 1'b0;
    #1;
    rst = 1'b0;
    step();
    checks++;
    if ({inst_addr, pc_out, inst_out, valid_out, halted} !== {32'd4, 32'd4, 32'hE3A00000, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL post_rst_fetch got %h expected %h", {inst_addr, pc_out, inst_out, valid_out, halted}, {32'd4, 32'd4, 32'hE3A00000, 1'b1, 1'b0});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_freeze();
    test_branch_over_freeze();
    test_halt();
    test_align_wrap();
    test_reset_mid_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
